// File: rtl/lc3b_types.sv
// Shared types and constants for the LC-3b memory hierarchy.
// This file holds the L2 controller state encoding and the way-select helpers.
package lc3b_types;

    typedef enum logic [1:0] {
        L2_IDLE      = 2'd0,
        L2_CHECK     = 2'd1,
        L2_WRITEBACK = 2'd2,
        L2_FILL      = 2'd3
    } l2_state_t;

    localparam logic [2:0] L2_PMEM_SEL_REQ = 3'd4;
    localparam int         L2_WAYS         = 4;

    // Converts a one-hot way vector to a way index. A vector that is not one-hot maps to way 0.
    function automatic logic [1:0] onehot_to_way(input logic [L2_WAYS-1:0] oh);
        logic [1:0] way;
        case (oh)
            4'b0001: way = 2'd0;
            4'b0010: way = 2'd1;
            4'b0100: way = 2'd2;
            4'b1000: way = 2'd3;
            default: way = 2'd0;
        endcase
        return way;
    endfunction

endpackage

// File: rtl/l2_cache_control_plru.sv
// Tree pseudo-LRU for one 4-way set.
// Picks the victim way from the PLRU bits and computes the updated bits for a hit.
module l2_plru
    import lc3b_types::*;
(
    input  logic [2:0]         lru_out,
    input  logic [L2_WAYS-1:0] hit_set,
    output logic [1:0]         victim_way,
    output logic [2:0]         lru_in
);

    logic [1:0] hit_way_s;

    assign hit_way_s = onehot_to_way(hit_set);

    // Victim selection: lru[2] picks a pair of ways, then lru[0] or lru[1] picks a way within that pair.
    always_comb begin
        victim_way = 2'd0;
        if (lru_out[2] == 1'b0) begin
            victim_way = lru_out[0] ? 2'd2 : 2'd3;
        end else begin
            victim_way = lru_out[1] ? 2'd0 : 2'd1;
        end
    end

    // Points the tree away from the way that was just used. Bits of the other pair keep their value.
    always_comb begin
        lru_in = lru_out;
        case (hit_way_s)
            2'd0: begin lru_in[2] = 1'b0; lru_in[1] = 1'b0; end
            2'd1: begin lru_in[2] = 1'b0; lru_in[1] = 1'b1; end
            2'd2: begin lru_in[2] = 1'b1; lru_in[0] = 1'b0; end
            2'd3: begin lru_in[2] = 1'b1; lru_in[0] = 1'b1; end
            default: lru_in = lru_out;
        endcase
    end

endmodule

// File: rtl/l2_cache_control.sv
// Control FSM for the 4-way write-back/write-allocate L2.
// It handles hit service, dirty-victim writeback, line fill, PLRU upkeep and the hit/miss counters.
module l2_cache_control
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 l2_read,
    input  logic                 l2_write,
    output logic                 l2_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit,
    input  logic [3:0]           hit_set,
    input  logic [2:0]           lru_out,
    input  logic                 v0_out,
    input  logic                 v1_out,
    input  logic                 v2_out,
    input  logic                 v3_out,
    input  logic                 d0_out,
    input  logic                 d1_out,
    input  logic                 d2_out,
    input  logic                 d3_out,
    output logic [2:0]           lru_in,
    output logic                 ld_lru,
    output logic                 v0_in,
    output logic                 v1_in,
    output logic                 v2_in,
    output logic                 v3_in,
    output logic                 ld_v0,
    output logic                 ld_v1,
    output logic                 ld_v2,
    output logic                 ld_v3,
    output logic                 d0_in,
    output logic                 d1_in,
    output logic                 d2_in,
    output logic                 d3_in,
    output logic                 ld_d0,
    output logic                 ld_d1,
    output logic                 ld_d2,
    output logic                 ld_d3,
    output logic                 ld_tag0,
    output logic                 ld_tag1,
    output logic                 ld_tag2,
    output logic                 ld_tag3,
    output logic                 ld_data0,
    output logic                 ld_data1,
    output logic                 ld_data2,
    output logic                 ld_data3,
    output logic                 write_mux_sel,
    output logic [2:0]           pmem_mux_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    l2_state_t            state_r, next_s;
    logic [1:0]           victim_r;
    logic                 from_idle_r;
    logic [CNT_WIDTH-1:0] hit_count_r, miss_count_r;

    logic [L2_WAYS-1:0] v_out_s, d_out_s, victim_mask_s;
    logic [L2_WAYS-1:0] ld_v_s, v_in_s, ld_d_s, d_in_s, ld_tag_s, ld_data_s;
    logic [1:0]         plru_victim_s;
    logic               req_s, victim_dirty_s;
    logic               l2_resp_s, pmem_read_s, pmem_write_s, ld_lru_s, write_mux_s;
    logic [2:0]         pmem_sel_s;

    assign v_out_s        = {v3_out, v2_out, v1_out, v0_out};
    assign d_out_s        = {d3_out, d2_out, d1_out, d0_out};
    assign req_s          = l2_read | l2_write;
    assign victim_mask_s  = 4'b0001 << victim_r;
    assign victim_dirty_s = v_out_s[plru_victim_s] & d_out_s[plru_victim_s];

    l2_plru u_plru (
        .lru_out    (lru_out),
        .hit_set    (hit_set),
        .victim_way (plru_victim_s),
        .lru_in     (lru_in)
    );

    // State register, plus a flag that marks a CHECK entered straight from IDLE, which is the only kind of hit the counter counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= L2_IDLE;
            from_idle_r <= 1'b0;
        end else begin
            state_r     <= next_s;
            from_idle_r <= (state_r == L2_IDLE);
        end
    end

    // The victim is latched in CHECK because lru_out can change once the datapath rewrites the set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            victim_r <= 2'd0;
        end else if ((state_r == L2_CHECK) && req_s && !hit) begin
            victim_r <= plru_victim_s;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_r  <= {CNT_WIDTH{1'b0}};
            miss_count_r <= {CNT_WIDTH{1'b0}};
        end else if ((state_r == L2_CHECK) && req_s) begin
            if (hit && from_idle_r && (hit_count_r != {CNT_WIDTH{1'b1}})) begin
                hit_count_r <= hit_count_r + CNT_WIDTH'(1);
            end
            if (!hit && (miss_count_r != {CNT_WIDTH{1'b1}})) begin
                miss_count_r <= miss_count_r + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        next_s       = state_r;
        l2_resp_s    = 1'b0;
        pmem_read_s  = 1'b0;
        pmem_write_s = 1'b0;
        ld_lru_s     = 1'b0;
        ld_v_s       = 4'b0000;
        v_in_s       = 4'b0000;
        ld_d_s       = 4'b0000;
        d_in_s       = 4'b0000;
        ld_tag_s     = 4'b0000;
        ld_data_s    = 4'b0000;
        write_mux_s  = 1'b0;
        pmem_sel_s   = L2_PMEM_SEL_REQ;
        case (state_r)
            L2_IDLE: begin
                if (req_s) begin
                    next_s = L2_CHECK;
                end else begin
                    next_s = L2_IDLE;
                end
            end
            L2_CHECK: begin
                if (!req_s) begin
                    next_s = L2_IDLE;
                end else if (hit) begin
                    l2_resp_s = 1'b1;
                    ld_lru_s  = 1'b1;
                    next_s    = L2_IDLE;
                    // A write (including read+write) merges the arbiter data into the hit way and marks it dirty.
                    if (l2_write) begin
                        ld_data_s   = hit_set;
                        write_mux_s = 1'b1;
                        ld_d_s      = hit_set;
                        d_in_s      = hit_set;
                    end else begin
                        ld_data_s   = 4'b0000;
                    end
                end else if (victim_dirty_s) begin
                    next_s = L2_WRITEBACK;
                end else begin
                    next_s = L2_FILL;
                end
            end
            L2_WRITEBACK: begin
                pmem_write_s = 1'b1;
                pmem_sel_s   = {1'b0, victim_r};
                if (pmem_resp) begin
                    ld_d_s = victim_mask_s;
                    next_s = L2_FILL;
                end else begin
                    next_s = L2_WRITEBACK;
                end
            end
            L2_FILL: begin
                pmem_read_s = 1'b1;
                if (pmem_resp) begin
                    ld_data_s = victim_mask_s;
                    ld_tag_s  = victim_mask_s;
                    ld_v_s    = victim_mask_s;
                    v_in_s    = victim_mask_s;
                    ld_d_s    = victim_mask_s;
                    next_s    = L2_CHECK;
                end else begin
                    next_s    = L2_FILL;
                end
            end
            default: next_s = L2_IDLE;
        endcase
    end

    assign l2_resp       = l2_resp_s;
    assign pmem_read     = pmem_read_s;
    assign pmem_write    = pmem_write_s;
    assign ld_lru        = ld_lru_s;
    assign write_mux_sel = write_mux_s;
    assign pmem_mux_sel  = pmem_sel_s;
    assign hit_count     = hit_count_r;
    assign miss_count    = miss_count_r;
    assign {v3_in, v2_in, v1_in, v0_in}             = v_in_s;
    assign {ld_v3, ld_v2, ld_v1, ld_v0}             = ld_v_s;
    assign {d3_in, d2_in, d1_in, d0_in}             = d_in_s;
    assign {ld_d3, ld_d2, ld_d1, ld_d0}             = ld_d_s;
    assign {ld_tag3, ld_tag2, ld_tag1, ld_tag0}     = ld_tag_s;
    assign {ld_data3, ld_data2, ld_data1, ld_data0} = ld_data_s;

endmodule

// File: tb/tb_l2_cache_control.sv
// Randomized bench for l2_cache_control. It emulates the tag/valid/dirty/PLRU arrays and a memory that answers with random latency.
// Each request is checked against a transaction-level cache model.
module tb_l2_cache_control;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, l2_read, l2_write, pmem_resp;
    logic [15:0] addr;
    logic        l2_resp, pmem_read, pmem_write, hit, ld_lru, write_mux_sel;
    logic [3:0]  hit_set, v_out, d_out, v_in, ld_v, d_in, ld_d, ld_tag, ld_data;
    logic [2:0]  lru_out, lru_in, pmem_mux_sel;
    logic [CW-1:0] hit_count, miss_count;

    // Emulated datapath arrays. Reset leaves them untouched.
    bit       dp_valid [32][4];
    bit       dp_dirty [32][4];
    bit [6:0] dp_tag   [32][4];
    bit [2:0] dp_lru   [32];

    // Reference model state.
    bit       m_valid [32][4];
    bit       m_dirty [32][4];
    bit [6:0] m_tag   [32][4];
    bit [2:0] m_lru   [32];
    int       m_hits, m_misses;

    int total = 0;
    int bad   = 0;

    logic [4:0] cur_set;
    logic [6:0] cur_tag;
    assign cur_set = addr[8:4];
    assign cur_tag = addr[15:9];

    always_comb begin
        hit_set = 4'b0000;
        v_out   = 4'b0000;
        d_out   = 4'b0000;
        for (int w = 0; w < 4; w++) begin
            v_out[w]   = dp_valid[cur_set][w];
            d_out[w]   = dp_dirty[cur_set][w];
            hit_set[w] = dp_valid[cur_set][w] && (dp_tag[cur_set][w] == cur_tag);
        end
        lru_out = dp_lru[cur_set];
    end
    assign hit = |hit_set;

    always @(posedge clk) begin
        for (int w = 0; w < 4; w++) begin
            if (ld_v[w])   dp_valid[cur_set][w] <= v_in[w];
            if (ld_d[w])   dp_dirty[cur_set][w] <= d_in[w];
            if (ld_tag[w]) dp_tag[cur_set][w]   <= cur_tag;
        end
        if (ld_lru) dp_lru[cur_set] <= lru_in;
    end

    l2_cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .l2_read(l2_read), .l2_write(l2_write),
        .l2_resp(l2_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .hit(hit), .hit_set(hit_set), .lru_out(lru_out),
        .v0_out(v_out[0]), .v1_out(v_out[1]), .v2_out(v_out[2]), .v3_out(v_out[3]),
        .d0_out(d_out[0]), .d1_out(d_out[1]), .d2_out(d_out[2]), .d3_out(d_out[3]),
        .lru_in(lru_in), .ld_lru(ld_lru),
        .v0_in(v_in[0]), .v1_in(v_in[1]), .v2_in(v_in[2]), .v3_in(v_in[3]),
        .ld_v0(ld_v[0]), .ld_v1(ld_v[1]), .ld_v2(ld_v[2]), .ld_v3(ld_v[3]),
        .d0_in(d_in[0]), .d1_in(d_in[1]), .d2_in(d_in[2]), .d3_in(d_in[3]),
        .ld_d0(ld_d[0]), .ld_d1(ld_d[1]), .ld_d2(ld_d[2]), .ld_d3(ld_d[3]),
        .ld_tag0(ld_tag[0]), .ld_tag1(ld_tag[1]), .ld_tag2(ld_tag[2]), .ld_tag3(ld_tag[3]),
        .ld_data0(ld_data[0]), .ld_data1(ld_data[1]), .ld_data2(ld_data[2]), .ld_data3(ld_data[3]),
        .write_mux_sel(write_mux_sel), .pmem_mux_sel(pmem_mux_sel),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_counts();
        chk("hit_count", 32'(hit_count), 32'(m_hits));
        chk("miss_count", 32'(miss_count), 32'(m_misses));
    endtask

    // Issues one request and checks the protocol, the chosen way and the resulting set contents against the model.
    task automatic run_req(input logic [15:0] a, input bit rd, input bit wr);
        int s, t, way, resp_c, last_resp_c, wb_start, fill_start, pend, delay, selbad, conflict;
        bit exp_hit, exp_wb, got, wb_seen, fill_seen;
        logic [2:0] wb_sel;
        logic [3:0] fill_ld, resp_ld_data;
        logic resp_ld_lru;
        logic [31:0] dp_vd, m_vd, dp_tags, m_tags;
        s = int'(a[8:4]);
        t = int'(a[15:9]);
        exp_hit = 1'b0; exp_wb = 1'b0; way = 0;
        for (int w = 0; w < 4; w++)
            if (m_valid[s][w] && (int'(m_tag[s][w]) == t)) begin exp_hit = 1'b1; way = w; end
        if (!exp_hit) begin
            way = m_lru[s][2] ? (1 - int'(m_lru[s][1])) : (3 - int'(m_lru[s][0]));
            exp_wb = m_valid[s][way] && m_dirty[s][way];
            m_valid[s][way] = 1'b1;
            m_dirty[s][way] = 1'b0;
            m_tag[s][way]   = 7'(t);
            if (m_misses < CMAX) m_misses++;
        end else begin
            if (m_hits < CMAX) m_hits++;
        end
        m_lru[s][2] = (way >= 2);
        if (way < 2) m_lru[s][1] = (way == 1);
        else         m_lru[s][0] = (way == 3);
        if (wr) m_dirty[s][way] = 1'b1;

        got = 1'b0; wb_seen = 1'b0; fill_seen = 1'b0; resp_c = -1; last_resp_c = -1;
        wb_start = -1; fill_start = -1; pend = 0; delay = $urandom_range(1, 4);
        selbad = 0; conflict = 0; wb_sel = 3'd7; fill_ld = 4'b0000;
        resp_ld_data = 4'b0000; resp_ld_lru = 1'b0;
        @(negedge clk);
        addr = a; l2_read = rd; l2_write = wr; pmem_resp = 1'b0;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) begin
                pend++;
                pmem_resp = (pend >= delay);
                if (pmem_resp) begin pend = 0; delay = $urandom_range(1, 4); end
            end else begin
                pend = 0;
                pmem_resp = ($urandom_range(0, 3) == 0);
            end
            #1;
            if (pmem_read && pmem_write) conflict++;
            if (l2_resp && (pmem_read || pmem_write)) conflict++;
            if (pmem_write) begin
                if (!wb_seen) wb_start = c;
                wb_seen = 1'b1;
                wb_sel = pmem_mux_sel;
                if (pmem_resp) begin
                    last_resp_c = c;
                    if (ld_d != (4'b0001 << wb_sel[1:0]) || d_in != 4'b0000 || ld_v != 4'b0000) selbad++;
                end
            end
            if (pmem_read) begin
                if (!fill_seen) fill_start = c;
                fill_seen = 1'b1;
                if (pmem_mux_sel != 3'd4 || write_mux_sel != 1'b0) selbad++;
                if (pmem_resp) begin
                    last_resp_c = c;
                    fill_ld = ld_data;
                    if (ld_tag != ld_data || ld_v != ld_data || v_in != ld_data ||
                        ld_d != ld_data || d_in != 4'b0000) selbad++;
                end
            end
            if (!pmem_read && !pmem_write && pmem_mux_sel != 3'd4) selbad++;
            if (l2_resp) begin
                got = 1'b1; resp_c = c;
                resp_ld_data = ld_data; resp_ld_lru = ld_lru;
                if (wr && (write_mux_sel != 1'b1 || ld_d != ld_data || d_in != ld_data)) selbad++;
            end
        end
        if (!got) chk("resp_timeout", 32'(0), 32'(1));
        chk("resp_cycle", 32'(resp_c), exp_hit ? 32'(1) : 32'(last_resp_c + 1));
        chk("resp_ld_lru", 32'(resp_ld_lru), 32'(1));
        chk("resp_ld_data", 32'(resp_ld_data), wr ? 32'(4'b0001 << way) : 32'(0));
        chk("writeback", 32'(wb_seen), 32'(exp_wb));
        if (exp_wb) chk("wb_sel", 32'(wb_sel), 32'(way));
        chk("fill", 32'(fill_seen), 32'(!exp_hit));
        if (!exp_hit) begin
            chk("fill_way", 32'(fill_ld), 32'(4'b0001 << way));
            chk("miss_start", exp_wb ? 32'(wb_start) : 32'(fill_start), 32'(2));
        end
        chk("ctl_bad", 32'(selbad), 32'(0));
        chk("conflict", 32'(conflict), 32'(0));
        @(negedge clk);
        l2_read = 1'b0; l2_write = 1'b0; pmem_resp = 1'b0;
        #1;
        chk("extra_resp", 32'(l2_resp), 32'(0));
        check_counts();
        dp_vd = 32'(dp_lru[s]); m_vd = 32'(m_lru[s]); dp_tags = 32'(0); m_tags = 32'(0);
        for (int w = 0; w < 4; w++) begin
            dp_vd[4 + w] = dp_valid[s][w]; m_vd[4 + w] = m_valid[s][w];
            dp_vd[8 + w] = dp_dirty[s][w]; m_vd[8 + w] = m_dirty[s][w];
            dp_tags[w*7 +: 7] = dp_tag[s][w]; m_tags[w*7 +: 7] = m_tag[s][w];
        end
        chk("set_lru_v_d", dp_vd, m_vd);
        chk("set_tags", dp_tags, m_tags);
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0; l2_read = 1'b0; l2_write = 1'b0; pmem_resp = 1'b0; addr = 16'h0000;
        m_hits = 0; m_misses = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_l2_resp", 32'(l2_resp), 32'(0));
        chk("rst_pmem_sel", 32'(pmem_mux_sel), 32'(4));
        chk("rst_pmem_rw", 32'({pmem_read, pmem_write}), 32'(0));
        check_counts();
        @(negedge clk);
        reset_n = 1'b1;

        run_req(16'h1230, 1'b1, 1'b0);
        run_req(16'h1230, 1'b1, 1'b0);

        // Drop reset while a fill is outstanding.
        @(negedge clk);
        addr = 16'h5670; l2_read = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #1;
            seen = pmem_read;
        end
        chk("mid_fill_reached", 32'(seen), 32'(1));
        reset_n = 1'b0;
        #1;
        m_hits = 0; m_misses = 0;
        chk("rst_fill_pmem_read", 32'(pmem_read), 32'(0));
        chk("rst_fill_l2_resp", 32'(l2_resp), 32'(0));
        chk("rst_fill_sel", 32'(pmem_mux_sel), 32'(4));
        check_counts();
        l2_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_l2_resp", 32'(l2_resp), 32'(0));
        chk("post_rst_pmem_rw", 32'({pmem_read, pmem_write}), 32'(0));

        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            int op;
            a = {7'($urandom_range(0, 7)), 5'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            op = $urandom_range(0, 2);
            run_req(a, op != 1, op != 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_cache_control.md
# l2_cache_control

Control FSM for the 4-way, 32-set, 128-bit-line, write-back/write-allocate L2 cache. Sits between the L1 arbiter and physical memory and drives every load, mux-select and bit-input of the L2 cache datapath. It also owns pseudo-LRU policy, dirty-victim writeback, line fill, and hit/miss statistics counters.

## Interface
- CNT_WIDTH, 16, width of each statistics counter
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- l2_read, l2_write  in  1 each  arbiter request; held with address/wdata until l2_resp
- l2_resp  out  1  one-cycle completion pulse to arbiter
- pmem_read, pmem_write  out  1 each  physical-memory request, held until pmem_resp
- pmem_resp  in  1  physical-memory completion pulse
- hit  in  1  any valid tag match
- hit_set  in  4  one-hot matching way
- lru_out  in  3  PLRU bits of indexed set
- v0_out..v3_out, d0_out..d3_out  in  1 each  valid/dirty bits of indexed set
- lru_in  out  3 / ld_lru  out  1  PLRU write
- v0_in..v3_in, ld_v0..ld_v3, d0_in..d3_in, ld_d0..ld_d3  out  1 each  valid/dirty writes
- ld_tag0..ld_tag3, ld_data0..ld_data3  out  1 each  tag/data array writes
- write_mux_sel  out  1  data source: 0 = p_rdata, 1 = l2_wdata
- pmem_mux_sel  out  3  0..3 = victim-way tag address, 4 = request address
- hit_count, miss_count  out  CNT_WIDTH each  statistics

## Operation
- States: IDLE, CHECK, WRITEBACK, FILL.
- IDLE: l2_read|l2_write -> CHECK. Both asserted: treated as write.
- CHECK, hit: read -> l2_resp=1, ld_lru. Write -> ld_data[w]=1, write_mux_sel=1, ld_d[w]=1/d_in=1, ld_lru, l2_resp=1. Next IDLE.
- CHECK, miss: latch victim way into victim register. Victim dirty and valid -> WRITEBACK, else FILL. Request dropped while in CHECK -> IDLE, no response.
- WRITEBACK: pmem_write=1, pmem_mux_sel=victim. On pmem_resp: ld_d[victim] with d_in=0, -> FILL.
- FILL: pmem_read=1, pmem_mux_sel=4, write_mux_sel=0. On pmem_resp: ld_data, ld_tag, ld_v(v_in=1), ld_d(d_in=0) of victim, -> CHECK. The re-check hits and completes the request.
- Victim is always taken from PLRU, never from invalid-way preference, so it matches datapath way-mux selection on a miss.
  - lru[2]=0: lru[0]=0 -> way3, lru[0]=1 -> way2.
  - lru[2]=1: lru[1]=0 -> way1, lru[1]=1 -> way0.
- PLRU update on hit to way w; bits not listed are unchanged:
  - way0 -> lru[2]=0, lru[1]=0.
  - way1 -> lru[2]=0, lru[1]=1.
  - way2 -> lru[2]=1, lru[0]=0.
  - way3 -> lru[2]=1, lru[0]=1.
- hit_count +1 per CHECK hit that follows directly from IDLE. miss_count +1 per CHECK miss. Both saturate at all-ones.
- All load/valid outputs default 0, pmem_mux_sel default 4, write_mux_sel default 0.

## Timing
- Reset (async, any state): state=IDLE, victim=0, counters=0. All outputs at defaults. pmem_read/pmem_write deassert immediately. Array contents are untouched; an in-flight pmem transaction is abandoned.
- Hit: request seen in IDLE cycle 0, l2_resp in cycle 1 (2-cycle latency).
- Clean miss: CHECK cycle 1, FILL from cycle 2. pmem_resp in cycle k writes arrays at end of k; l2_resp in cycle k+1.
- Dirty miss: WRITEBACK from cycle 2 until pmem_resp, then FILL, then CHECK.
- pmem_read and pmem_write are never asserted together and never both in one cycle with l2_resp.
- pmem_resp outside WRITEBACK/FILL is ignored.
- Registered state only; all datapath controls are Moore/Mealy combinational from state plus hit/pmem_resp.

## Structure
- lc3b_types gains:
  - l2_state_t enum.
  - Constants L2_PMEM_SEL_REQ=3'd4 and L2_WAYS=4.
- Sub-module l2_plru (combinational): lru_out -> victim way; (lru_out, hit way) -> lru_in.
- Top instantiates the FSM, victim register, counters and one l2_plru.

## Test plan
- Reset, then read addr 16'h1230 with all ways invalid, lru_out=000 -> victim way3, FILL with pmem_mux_sel=4. On pmem_resp: ld_data3/ld_tag3/ld_v3 high, then l2_resp; miss_count=1.
- Repeat read of 16'h1230 (way3 hit) -> l2_resp in cycle 1, lru_in=3'b1x1 with ld_lru; hit_count=1.
- Write hit to way1 -> ld_data1, write_mux_sel=1, d1_in=1/ld_d1, lru_in[2:1]=2'b01, single l2_resp.
- Miss with lru_out=100 and way1 valid+dirty -> WRITEBACK, pmem_write, pmem_mux_sel=1. Then FILL with pmem_mux_sel=4, then CHECK hit, l2_resp.
- Assert reset_n=0 mid-FILL -> pmem_read drops same cycle, state IDLE, counters 0, no l2_resp.
- Force miss_count to all-ones, then cause a miss -> miss_count holds at all-ones.
